// File: rtl/detector_jogada_pkg.sv
// detector_jogada_pkg
// Shared definitions for the button play detector: default parameter values
// and the FSM state encoding, which is also exported on db_estado.
package detector_jogada_pkg;

    localparam int unsigned N_BOTOES_PADRAO        = 4;
    localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 5;

    typedef enum logic [1:0] {
        ESPERA_SOLTAR = 2'd0,
        AGUARDA       = 2'd1,
        REGISTRA      = 2'd2,
        INVALIDA      = 2'd3
    } estado_t;

endpackage

// File: rtl/sincronizador_debounce.sv
// sincronizador_debounce
// Two-flop synchroniser followed by a saturating-counter debouncer for a
// vector of raw push-buttons.
//
// Ports:
//   clock     - system clock
//   reset     - asynchronous, active-low; clears synchroniser, counter, outputs
//   botoes    - raw asynchronous buttons, 1 = pressed
//   estavel   - debounced button vector
//   assentado - 1 while estavel holds a vector that the input still confirms
//               (the counter is saturated on an unchanged sample); 0 from reset
//               until the first vector has been accepted
module sincronizador_debounce #(
    parameter int unsigned N_BOTOES        = 4,
    parameter int unsigned DEBOUNCE_CICLOS = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] estavel,
    output logic                assentado
);

    localparam int unsigned          CNT_W   = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic [N_BOTOES-1:0] s1_q;
    logic [N_BOTOES-1:0] sinc_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_BOTOES-1:0] estavel_q, estavel_d;
    logic                assentado_q, assentado_d;
    logic                igual;

    // The sample about to enter the second stage is compared with the one it
    // holds, so a change is seen on the same edge it reaches sinc_q.
    assign igual = (s1_q == sinc_q);

    always_comb begin
        cnt_d       = cnt_q;
        estavel_d   = estavel_q;
        assentado_d = 1'b0;
        if (!igual) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            estavel_d   = sinc_q;
            assentado_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q        <= '0;
            sinc_q      <= '0;
            cnt_q       <= '0;
            estavel_q   <= '0;
            assentado_q <= 1'b0;
        end else begin
            s1_q        <= botoes;
            sinc_q      <= s1_q;
            cnt_q       <= cnt_d;
            estavel_q   <= estavel_d;
            assentado_q <= assentado_d;
        end
    end

    assign estavel   = estavel_q;
    assign assentado = assentado_q;

endmodule

// File: rtl/detector_jogada.sv
// detector_jogada
// Input stage in front of the memory game: debounces the button vector and
// turns each single-button press into a registered one-hot play with a
// one-cycle strobe. Multi-button presses produce a one-cycle invalid strobe.
// Every press must be released before another play is accepted.
//
// Ports:
//   clock           - system clock (1 kHz nominal)
//   reset           - asynchronous, active-low; clears all state
//   botoes          - raw buttons, 1 = pressed
//   habilita        - game is waiting for a play
//   limpa           - synchronous clear of jogada and the FSM
//   jogada          - last valid one-hot play, held
//   tem_jogada      - 1-cycle pulse: new play in jogada
//   jogada_invalida - 1-cycle pulse: more than one button pressed
//   db_estado       - current FSM state encoding
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int unsigned N_BOTOES        = N_BOTOES_PADRAO,
    parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    input  logic                limpa,
    output logic [N_BOTOES-1:0] jogada,
    output logic                tem_jogada,
    output logic                jogada_invalida,
    output logic [1:0]          db_estado
);

    logic [N_BOTOES-1:0] estavel;
    logic                assentado;
    logic                um_so;

    estado_t             estado_q, estado_d;
    logic [N_BOTOES-1:0] jogada_q, jogada_d;
    logic                tem_jogada_q, tem_jogada_d;
    logic                jogada_invalida_q, jogada_invalida_d;

    sincronizador_debounce #(
        .N_BOTOES        (N_BOTOES),
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
    ) u_sinc_db (
        .clock     (clock),
        .reset     (reset),
        .botoes    (botoes),
        .estavel   (estavel),
        .assentado (assentado)
    );

    assign um_so = (estavel != '0) &&
                   ((estavel & (estavel - N_BOTOES'(1))) == '0);

    always_comb begin
        estado_d = estado_q;
        jogada_d = jogada_q;
        if (limpa) begin
            estado_d = ESPERA_SOLTAR;
            jogada_d = '0;
        end else begin
            unique case (estado_q)
                // Re-arm only on a confirmed all-released vector, so buttons
                // held through reset never look like a release.
                ESPERA_SOLTAR: begin
                    if (estavel == '0 && assentado) begin
                        estado_d = AGUARDA;
                    end
                end
                AGUARDA: begin
                    if (habilita && estavel != '0) begin
                        if (um_so) begin
                            estado_d = REGISTRA;
                            jogada_d = estavel;
                        end else begin
                            estado_d = INVALIDA;
                        end
                    end
                end
                REGISTRA: estado_d = ESPERA_SOLTAR;
                INVALIDA: estado_d = ESPERA_SOLTAR;
                default:  estado_d = ESPERA_SOLTAR;
            endcase
        end
        // Strobes are registered alongside the state they belong to.
        tem_jogada_d      = (estado_d == REGISTRA);
        jogada_invalida_d = (estado_d == INVALIDA);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q          <= ESPERA_SOLTAR;
            jogada_q          <= '0;
            tem_jogada_q      <= 1'b0;
            jogada_invalida_q <= 1'b0;
        end else begin
            estado_q          <= estado_d;
            jogada_q          <= jogada_d;
            tem_jogada_q      <= tem_jogada_d;
            jogada_invalida_q <= jogada_invalida_d;
        end
    end

    assign jogada          = jogada_q;
    assign tem_jogada      = tem_jogada_q;
    assign jogada_invalida = jogada_invalida_q;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada
// Directed stimulus for detector_jogada with a behavioural reference model
// (sample history window + press/release bookkeeping) checked every cycle,
// plus hand-computed expectations for latency, pulse counts and held values.
module tb_detector_jogada;

    localparam int unsigned N = 4;
    localparam int unsigned D = 5;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] botoes = '0;
    logic         habilita = 1'b1;
    logic         limpa = 1'b0;
    logic [N-1:0] jogada;
    logic         tem_jogada;
    logic         jogada_invalida;
    logic [1:0]   db_estado;

    int total = 0;
    int bad = 0;

    detector_jogada #(
        .N_BOTOES        (N),
        .DEBOUNCE_CICLOS (D)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .botoes          (botoes),
        .habilita        (habilita),
        .limpa           (limpa),
        .jogada          (jogada),
        .tem_jogada      (tem_jogada),
        .jogada_invalida (jogada_invalida),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[0] is the newest sampled button vector. A vector is accepted once
    // the last D+1 entries agree; reset leaves two zero entries (the cleared
    // synchroniser stages).
    logic [N-1:0] hist[$];
    logic [N-1:0] m_est;
    logic         m_settled;
    logic         m_armed;
    logic         m_tem;
    logic         m_inv;
    logic [N-1:0] m_jog;

    task automatic model_clear();
        hist.delete();
        hist.push_front('0);
        hist.push_front('0);
        m_est     = '0;
        m_settled = 1'b0;
        m_armed   = 1'b0;
        m_tem     = 1'b0;
        m_inv     = 1'b0;
        m_jog     = '0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                model_clear();
            end else begin
                bit stab;
                // play bookkeeping uses the debounced view from before this edge
                if (limpa) begin
                    m_armed = 1'b0; m_jog = '0; m_tem = 1'b0; m_inv = 1'b0;
                end else if (m_tem || m_inv) begin
                    m_armed = 1'b0; m_tem = 1'b0; m_inv = 1'b0;
                end else if (!m_armed) begin
                    m_armed = (m_est == '0) && m_settled;
                end else if (habilita && m_est != '0) begin
                    m_armed = 1'b0;
                    if ($countones(m_est) == 1) begin
                        m_jog = m_est;
                        m_tem = 1'b1;
                    end else begin
                        m_inv = 1'b1;
                    end
                end
                stab = (hist.size() == D + 1);
                foreach (hist[i]) if (hist[i] != hist[0]) stab = 1'b0;
                if (stab) m_est = hist[0];
                m_settled = stab;
                hist.push_front(botoes);
                if (hist.size() > D + 1) void'(hist.pop_back());
            end
        end
    end

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            chk("cyc_jogada", 32'(jogada), 32'(m_jog));
            chk("cyc_tem", 32'(tem_jogada), 32'(m_tem));
            chk("cyc_inv", 32'(jogada_invalida), 32'(m_inv));
            chk("cyc_estado", 32'(db_estado),
                m_tem ? 32'd2 : m_inv ? 32'd3 : m_armed ? 32'd1 : 32'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run(input int n, output int ntem, output int ninv);
        ntem = 0;
        ninv = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (tem_jogada) ntem++;
            if (jogada_invalida) ninv++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, ni, nt2, ni2, first;

        @(negedge clock);
        chk("rst_jogada", 32'(jogada), 32'h0);
        chk("rst_estado", 32'(db_estado), 32'h0);
        chk("rst_tem", 32'(tem_jogada), 32'h0);
        reset = 1'b1;
        run(10, nt, ni);
        chk("idle_pulses", 32'(nt + ni), 32'd0);

        // valid press: 0001 for 10 cycles, pulse 8 edges after first sample
        botoes = 4'b0001;
        first = 0;
        nt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (i == 10) botoes = 4'b0000;
            if (tem_jogada) begin
                nt++;
                if (first == 0) first = i;
            end
        end
        chk("valid_latency", 32'(first), 32'd8);
        chk("valid_count", 32'(nt), 32'd1);
        chk("valid_held", 32'(jogada), 32'h1);

        // glitch of 3 cycles
        botoes = 4'b0100;
        run(3, nt, ni);
        botoes = 4'b0000;
        run(12, nt2, ni2);
        chk("glitch_pulses", 32'(nt + ni + nt2 + ni2), 32'd0);
        chk("glitch_jogada", 32'(jogada), 32'h1);

        // multi-button press
        botoes = 4'b0011;
        run(10, nt, ni);
        botoes = 4'b0000;
        run(12, nt2, ni2);
        chk("multi_inv", 32'(ni + ni2), 32'd1);
        chk("multi_tem", 32'(nt + nt2), 32'd0);
        chk("multi_jogada", 32'(jogada), 32'h1);

        // hold and re-press
        botoes = 4'b1000;
        run(40, nt, ni);
        chk("hold_count", 32'(nt), 32'd1);
        botoes = 4'b0000;
        run(10, nt, ni);
        botoes = 4'b1000;
        run(10, nt, ni);
        chk("repress_count", 32'(nt), 32'd1);
        chk("repress_jogada", 32'(jogada), 32'h8);
        botoes = 4'b0000;
        run(12, nt, ni);

        // habilita gating then limpa
        habilita = 1'b0;
        botoes = 4'b0010;
        run(20, nt, ni);
        chk("gated_pulses", 32'(nt + ni), 32'd0);
        habilita = 1'b1;
        @(negedge clock);
        chk("hab_rise_tem", 32'(tem_jogada), 32'h1);
        chk("hab_rise_jogada", 32'(jogada), 32'h2);
        limpa = 1'b1;
        @(negedge clock);
        chk("limpa_jogada", 32'(jogada), 32'h0);
        chk("limpa_estado", 32'(db_estado), 32'h0);
        limpa = 1'b0;
        run(15, nt, ni);
        chk("limpa_held_pulses", 32'(nt + ni), 32'd0);
        botoes = 4'b0000;
        run(10, nt, ni);
        botoes = 4'b0010;
        run(10, nt, ni);
        chk("post_limpa_count", 32'(nt), 32'd1);
        botoes = 4'b0000;
        run(12, nt, ni);

        // reset mid-debounce with the button still held afterwards
        botoes = 4'b0001;
        run(3, nt, ni);
        #2 reset = 1'b0;
        #1;
        chk("midrst_jogada", 32'(jogada), 32'h0);
        chk("midrst_tem", 32'(tem_jogada), 32'h0);
        chk("midrst_inv", 32'(jogada_invalida), 32'h0);
        chk("midrst_estado", 32'(db_estado), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        run(20, nt, ni);
        chk("held_rst_pulses", 32'(nt + ni), 32'd0);
        botoes = 4'b0000;
        run(10, nt, ni);
        botoes = 4'b0001;
        run(10, nt, ni);
        chk("after_rst_count", 32'(nt), 32'd1);
        chk("after_rst_jogada", 32'(jogada), 32'h1);
        botoes = 4'b0000;
        run(5, nt, ni);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
